// File: rtl/audio_fs_pkg.sv
// rtl/audio_fs_pkg.sv - shared constants and helpers for the PCM fs timing generator
//
// Purpose: fs_sel encodings plus constant functions used to size the NCO accumulator.
// Ports: none (package).

package audio_fs_pkg;

  // fs_sel encodings
  localparam logic [1:0] FS_SEL_32K  = 2'd0;
  localparam logic [1:0] FS_SEL_44K1 = 2'd1;
  localparam logic [1:0] FS_SEL_48K  = 2'd2;
  localparam logic [1:0] FS_SEL_96K  = 2'd3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // One spare bit so acc + inc (both below the modulus) cannot overflow.
  function automatic int acc_width(input int modulus);
    return clog2(modulus) + 1;
  endfunction

endpackage

// File: rtl/audio_fs_timing_nco.sv
// rtl/audio_fs_timing_nco.sv - fractional accumulator producing the fs tick and pcm_fs
//
// Purpose: exact-average rate generator. Each cycle acc advances by inc; a wrap past
//          MODULUS produces a registered one-cycle tick. The increment only changes in
//          the tick cycle, and acc is never cleared, so rate changes are phase continuous.
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   inc_sel  in   increment to adopt at the next tick
//   tick     out  one cycle per sample period
//   pcm_fs   out  high from the tick cycle until acc first reaches MODULUS/2

module fs_nco
  import audio_fs_pkg::*;
#(
  parameter int MODULUS   = 74250000,
  parameter int INC_WIDTH = 28,
  parameter int INC_INIT  = 32000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [INC_WIDTH-1:0] inc_sel,
  output logic                 tick,
  output logic                 pcm_fs
);

  localparam int            AW   = acc_width(MODULUS);
  localparam logic [AW-1:0] MOD  = AW'(MODULUS);
  localparam logic [AW-1:0] HALF = AW'(MODULUS / 2);

  logic [AW-1:0]        acc_q, acc_d;
  logic [AW-1:0]        sum;
  logic [INC_WIDTH-1:0] inc_q, inc_d;
  logic                 tick_q, tick_d;
  logic                 pcm_fs_q, pcm_fs_d;

  always_comb begin
    sum      = acc_q + AW'(inc_q);
    acc_d    = sum;
    tick_d   = 1'b0;
    pcm_fs_d = pcm_fs_q;
    inc_d    = inc_q;
    if (sum >= MOD) begin
      acc_d    = sum - MOD;
      tick_d   = 1'b1;
      pcm_fs_d = 1'b1;
    end else if (sum >= HALF) begin
      // Decided on the next acc value so pcm_fs is already low in the
      // first cycle where acc >= MODULUS/2.
      pcm_fs_d = 1'b0;
    end
    if (tick_q) begin
      inc_d = inc_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      inc_q    <= INC_WIDTH'(INC_INIT);
      tick_q   <= 1'b0;
      pcm_fs_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      tick_q   <= tick_d;
      pcm_fs_q <= pcm_fs_d;
    end
  end

  assign tick   = tick_q;
  assign pcm_fs = pcm_fs_q;

endmodule

// File: rtl/audio_fs_timing.sv
// rtl/audio_fs_timing.sv - PCM sample-rate timing generator with sample holding buffer
//
// Purpose: selects one of four rates for the NCO, requests a sample set each period,
//          holds the newest set in a stage register and presents it on pcm_out at
//          the following fs tick; flags periods with no fresh sample as underruns.
// Build option: AUDIO_FS_TIMING_MUTE_ON_UNDERRUN_EN - when defined, pcm_out is
//          zeroed on underrun; otherwise the last sample set is repeated.
// Ports:
//   clk           in   video clock
//   reset_n       in   asynchronous active-low reset
//   fs_sel        in   rate select (adopted at the next tick)
//   sample_req    out  one-cycle request, cycle after the tick
//   sample_valid  in   pcm_in carries a sample set
//   pcm_in        in   channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   pcm_fs        out  sample clock, ~50% duty
//   pcm_out       out  held sample set
//   underrun      out  one-cycle pulse, cycle after a tick that found no sample
//   underrun_cnt  out  saturating underrun count

module audio_fs_timing
  import audio_fs_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 74250000,
  parameter int FS0_HZ        = 32000,
  parameter int FS1_HZ        = 44100,
  parameter int FS2_HZ        = 48000,
  parameter int FS3_HZ        = 96000,
  parameter int CHANNELS      = 2,
  parameter int SAMPLE_WIDTH  = 24
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [1:0]                       fs_sel,
  output logic                             sample_req,
  input  logic                             sample_valid,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] pcm_in,
  output logic                             pcm_fs,
  output logic [CHANNELS*SAMPLE_WIDTH-1:0] pcm_out,
  output logic                             underrun,
  output logic [7:0]                       underrun_cnt
);

  localparam int AW = acc_width(CLOCK_FREQ_HZ);
  localparam int PW = CHANNELS * SAMPLE_WIDTH;

  logic [AW-1:0] inc_sel;
  logic          tick;

  always_comb begin
    inc_sel = AW'(FS3_HZ);
    case (fs_sel)
      FS_SEL_32K:  inc_sel = AW'(FS0_HZ);
      FS_SEL_44K1: inc_sel = AW'(FS1_HZ);
      FS_SEL_48K:  inc_sel = AW'(FS2_HZ);
      default:     inc_sel = AW'(FS3_HZ);
    endcase
  end

  fs_nco #(
    .MODULUS   (CLOCK_FREQ_HZ),
    .INC_WIDTH (AW),
    .INC_INIT  (FS0_HZ)
  ) u_nco (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_sel (inc_sel),
    .tick    (tick),
    .pcm_fs  (pcm_fs)
  );

  logic [PW-1:0] stage_q, stage_d;
  logic [PW-1:0] pcm_out_q, pcm_out_d;
  logic          pend_q, pend_d;
  logic          sample_req_q, sample_req_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    stage_d        = stage_q;
    pend_d         = pend_q;
    pcm_out_d      = pcm_out_q;
    underrun_cnt_d = underrun_cnt_q;
    sample_req_d   = tick;
    underrun_d     = tick & ~pend_q;
    if (tick) begin
      if (pend_q) begin
        pcm_out_d = stage_q;
        pend_d    = 1'b0;
      end else begin
`ifdef AUDIO_FS_TIMING_MUTE_ON_UNDERRUN_EN
        pcm_out_d = '0;
`endif
        if (underrun_cnt_q != 8'hFF) begin
          underrun_cnt_d = underrun_cnt_q + 8'd1;
        end
      end
    end
    // Evaluated after the transfer: a set arriving in the tick cycle is kept
    // for the next period rather than being consumed by this tick.
    if (sample_valid) begin
      stage_d = pcm_in;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q        <= '0;
      pcm_out_q      <= '0;
      pend_q         <= 1'b0;
      sample_req_q   <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 8'd0;
    end else begin
      stage_q        <= stage_d;
      pcm_out_q      <= pcm_out_d;
      pend_q         <= pend_d;
      sample_req_q   <= sample_req_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign sample_req   = sample_req_q;
  assign pcm_out      = pcm_out_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule
